// File: rtl/fifo_write_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// uart_defs
//   Shared definitions for the UART Fifo write-side logic.
//   - UART_WORD_WIDTH : width of a Fifo word (dataIn)
//   - ARB_*           : state encodings of the Fifo write arbiter FSM
// ----------------------------------------------------------------------------
package uart_defs;

    localparam int UART_WORD_WIDTH = 16;

    localparam logic [1:0] ARB_IDLE    = 2'd0;
    localparam logic [1:0] ARB_GRANT   = 2'd1;
    localparam logic [1:0] ARB_RELEASE = 2'd2;

endpackage

// File: rtl/fifo_write_arbiter_picker.sv
// ----------------------------------------------------------------------------
// rr_priority_picker
//   Combinational round-robin picker: returns the first asserted request at
//   or after 'pointer', wrapping from NUM_REQ-1 back to 0.
// Ports
//   req     in  NUM_REQ    request vector
//   pointer in  IDX_WIDTH  highest-priority index (must be < NUM_REQ)
//   valid   out 1          at least one request asserted
//   idx     out IDX_WIDTH  chosen requester
// ----------------------------------------------------------------------------
module rr_priority_picker #(
    parameter int NUM_REQ   = 4,
    parameter int IDX_WIDTH = 2
) (
    input  logic [NUM_REQ-1:0]   req,
    input  logic [IDX_WIDTH-1:0] pointer,
    output logic                 valid,
    output logic [IDX_WIDTH-1:0] idx
);

    // One extra bit so pointer+offset cannot overflow before the wrap test.
    localparam logic [IDX_WIDTH:0] NUM_REQ_W = (IDX_WIDTH + 1)'(NUM_REQ);

    logic [IDX_WIDTH-1:0] cand_idx [NUM_REQ];
    logic [NUM_REQ-1:0]   cand_hit;

    // Candidate gi is the requester sitting gi places after the pointer.
    // The wrap is done against NUM_REQ, so non-power-of-2 sizes stay in range.
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cand
            logic [IDX_WIDTH:0] sum;
            assign sum          = {1'b0, pointer} + (IDX_WIDTH + 1)'(gi);
            assign cand_idx[gi] = (sum >= NUM_REQ_W) ? IDX_WIDTH'(sum - NUM_REQ_W)
                                                     : IDX_WIDTH'(sum);
            assign cand_hit[gi] = req[cand_idx[gi]];
        end
    endgenerate

    // Scan from the farthest candidate down so the nearest hit wins.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (cand_hit[k]) begin
                valid = 1'b1;
                idx   = cand_idx[k];
            end
        end
    end

endmodule

// File: rtl/fifo_write_arbiter.sv
// ----------------------------------------------------------------------------
// fifo_write_arbiter
//   Shares the single write port of the UART Fifo between NUM_REQ producers
//   using round-robin arbitration. Each grant sequences exactly one Fifo write.
// Ports
//   clk       in  1                   rising-edge clock
//   rst       in  1                   synchronous active-high reset
//   req       in  NUM_REQ             per-requester write request
//   dataIns   in  NUM_REQ*DATA_WIDTH  requester i word at [i*DATA_WIDTH +: DATA_WIDTH]
//   ack       out NUM_REQ             one-cycle pulse: requester word accepted
//   full      in  1                   Fifo full flag
//   writeReq  out 1                   Fifo write request
//   writeAck  in  1                   Fifo write acknowledge
//   dataIn    out DATA_WIDTH          Fifo write data (registered)
//   grantIdx  out IDX_WIDTH           current / last granted requester
//   busy      out 1                   high while in GRANT or RELEASE
// ----------------------------------------------------------------------------
module fifo_write_arbiter
    import uart_defs::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = UART_WORD_WIDTH,
    parameter int IDX_WIDTH  = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] dataIns,
    output logic [NUM_REQ-1:0]            ack,
    input  logic                          full,
    output logic                          writeReq,
    input  logic                          writeAck,
    output logic [DATA_WIDTH-1:0]         dataIn,
    output logic [IDX_WIDTH-1:0]          grantIdx,
    output logic                          busy
);

    logic [1:0]            state_reg,     state_next;
    logic [IDX_WIDTH-1:0]  pointer_reg,   pointer_next;
    logic [IDX_WIDTH-1:0]  grant_reg,     grant_next;
    logic [NUM_REQ-1:0]    ack_reg,       ack_next;
    logic                  write_req_reg, write_req_next;
    logic [DATA_WIDTH-1:0] data_reg,      data_next;
    logic                  busy_reg,      busy_next;

    logic                  pick_valid;
    logic [IDX_WIDTH-1:0]  pick_idx;
    logic [DATA_WIDTH-1:0] word [NUM_REQ];

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_word
            assign word[gi] = dataIns[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    rr_priority_picker #(
        .NUM_REQ   (NUM_REQ),
        .IDX_WIDTH (IDX_WIDTH)
    ) u_picker (
        .req     (req),
        .pointer (pointer_reg),
        .valid   (pick_valid),
        .idx     (pick_idx)
    );

    always_comb begin
        state_next     = state_reg;
        pointer_next   = pointer_reg;
        grant_next     = grant_reg;
        ack_next       = '0;            // ack is a single-cycle pulse
        write_req_next = write_req_reg;
        data_next      = data_reg;

        case (state_reg)
            ARB_IDLE: begin
                // No new grant while the Fifo reports full.
                if (pick_valid && !full) begin
                    state_next     = ARB_GRANT;
                    grant_next     = pick_idx;
                    data_next      = word[pick_idx];
                    write_req_next = 1'b1;
                end
            end
            ARB_GRANT: begin
                // req and full are deliberately ignored here: once granted,
                // the latched word is written no matter what.
                if (writeAck) begin
                    state_next          = ARB_RELEASE;
                    write_req_next      = 1'b0;
                    ack_next[grant_reg] = 1'b1;
                    pointer_next        = (grant_reg == IDX_WIDTH'(NUM_REQ - 1))
                                          ? '0 : grant_reg + 1'b1;
                end
            end
            ARB_RELEASE: begin
                // One cycle to let the requester drop req before re-arbitration.
                state_next = ARB_IDLE;
            end
            default: begin
                state_next     = ARB_IDLE;
                write_req_next = 1'b0;
            end
        endcase

        busy_next = (state_next != ARB_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ARB_IDLE;
            pointer_reg   <= '0;
            grant_reg     <= '0;
            ack_reg       <= '0;
            write_req_reg <= 1'b0;
            data_reg      <= '0;
            busy_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            pointer_reg   <= pointer_next;
            grant_reg     <= grant_next;
            ack_reg       <= ack_next;
            write_req_reg <= write_req_next;
            data_reg      <= data_next;
            busy_reg      <= busy_next;
        end
    end

    assign ack      = ack_reg;
    assign writeReq = write_req_reg;
    assign dataIn   = data_reg;
    assign grantIdx = grant_reg;
    assign busy     = busy_reg;

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// ----------------------------------------------------------------------------
// tb_fifo_write_arbiter
//   Bench acts as the requesters and as the Fifo. A transaction-level model
//   (pointer + "first pending at or after pointer") predicts each grant.
// ----------------------------------------------------------------------------
module tb_fifo_write_arbiter;

    localparam int N  = 4;
    localparam int DW = 16;
    localparam int IW = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [N-1:0]  req = '0;
    logic [N*DW-1:0] data_ins = '0;
    logic [N-1:0]  ack;
    logic          full = 1'b0;
    logic          write_req;
    logic          write_ack = 1'b0;
    logic [DW-1:0] data_in;
    logic [IW-1:0] grant_idx;
    logic          busy;

    int            n_checks = 0;
    int            n_fail   = 0;
    int            ptr_model = 0;
    int            wait_cnt [N];
    logic [DW-1:0] words [N];

    fifo_write_arbiter #(
        .NUM_REQ    (N),
        .DATA_WIDTH (DW),
        .IDX_WIDTH  (IW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .dataIns  (data_ins),
        .ack      (ack),
        .full     (full),
        .writeReq (write_req),
        .writeAck (write_ack),
        .dataIn   (data_in),
        .grantIdx (grant_idx),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, required completion");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_word(input int i, input logic [DW-1:0] w);
        words[i] = w;
        data_ins[i*DW +: DW] = w;
    endtask

    // First pending requester at or after the pointer, wrapping modulo N.
    function automatic int model_pick(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++) begin
            if (r[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    // One full write: grant, random Fifo stall, writeAck, ack pulse, release.
    // Entered with the arbiter idle and req already set up.
    task automatic do_write(input bit drop_in_grant, input bit keep_req,
                            output int got_idx, output logic [DW-1:0] got_data);
        int           exp_i;
        int           hold;
        logic [N-1:0] exp_ack;
        exp_i = model_pick(req, ptr_model);
        tick();
        check_eq("wreq_rise", write_req, 1);
        check_eq("grant_idx", grant_idx, exp_i);
        check_eq("data_in", data_in, words[exp_i]);
        check_eq("busy_grant", busy, 1);
        check_eq("ack_quiet", ack, 0);
        got_idx  = int'(grant_idx);
        got_data = data_in;
        if (drop_in_grant) req[exp_i] = 1'b0;
        hold = $urandom_range(0, 3);
        for (int c = 0; c < hold; c++) begin
            full = 1'($urandom_range(0, 1));
            tick();
            check_eq("wreq_hold", write_req, 1);
            check_eq("data_hold", data_in, words[exp_i]);
            check_eq("ack_hold", ack, 0);
        end
        full      = 1'b0;
        write_ack = 1'b1;
        tick();
        write_ack = 1'b0;
        exp_ack = '0;
        exp_ack[exp_i] = 1'b1;
        check_eq("ack_pulse", ack, exp_ack);
        check_eq("wreq_fall", write_req, 0);
        check_eq("busy_release", busy, 1);
        check_eq("fair_wait", (wait_cnt[exp_i] <= N - 1), 1);
        for (int i = 0; i < N; i++) begin
            if (i != exp_i && req[i]) wait_cnt[i]++;
        end
        wait_cnt[exp_i] = 0;
        ptr_model = (exp_i + 1) % N;
        if (!keep_req) req[exp_i] = 1'b0;
        tick();
        check_eq("ack_clear", ack, 0);
        check_eq("busy_idle", busy, 0);
        check_eq("wreq_idle", write_req, 0);
        $display("write: grant=%0d data=0x%0h stall=%0d", exp_i, words[exp_i], hold);
    endtask

    int            gi_obs;
    logic [DW-1:0] gd_obs;
    logic [DW-1:0] rr_exp [5];

    initial begin
        for (int i = 0; i < N; i++) begin
            wait_cnt[i] = 0;
            set_word(i, '0);
        end

        // Reset: hold 5 cycles, every output at its reset value.
        rst = 1'b1;
        for (int c = 0; c < 5; c++) tick();
        check_eq("rst_ack", ack, 0);
        check_eq("rst_wreq", write_req, 0);
        check_eq("rst_data", data_in, 0);
        check_eq("rst_grant", grant_idx, 0);
        check_eq("rst_busy", busy, 0);
        rst = 1'b0;
        tick();
        check_eq("idle_wreq", write_req, 0);

        // Round-robin with all four requesters held high.
        for (int i = 0; i < N; i++) set_word(i, 16'h0010 + 16'(i));
        rr_exp[0] = 16'h0010; rr_exp[1] = 16'h0011; rr_exp[2] = 16'h0012;
        rr_exp[3] = 16'h0013; rr_exp[4] = 16'h0010;
        req = 4'b1111;
        for (int t = 0; t < 5; t++) begin
            do_write(1'b0, 1'b1, gi_obs, gd_obs);
            check_eq("rr_order", gd_obs, rr_exp[t]);
        end
        req = '0;
        for (int i = 0; i < N; i++) wait_cnt[i] = 0;

        // Single request from requester 2.
        set_word(2, 16'h00a5);
        req = 4'b0100;
        do_write(1'b0, 1'b0, gi_obs, gd_obs);
        check_eq("single_idx", gi_obs, 2);
        check_eq("single_data", gd_obs, 16'h00a5);

        // Wrap: pointer is 3 now; 0011 -> 0 then 1.
        set_word(0, 16'h1000);
        set_word(1, 16'h1001);
        req = 4'b0011;
        do_write(1'b0, 1'b0, gi_obs, gd_obs);
        check_eq("wrap_first", gi_obs, 0);
        do_write(1'b0, 1'b0, gi_obs, gd_obs);
        check_eq("wrap_second", gi_obs, 1);
        req = 4'b0100;
        do_write(1'b0, 1'b0, gi_obs, gd_obs);
        set_word(3, 16'h3333);
        req = 4'b1001;
        do_write(1'b0, 1'b0, gi_obs, gd_obs);
        check_eq("wrap_ptr3", gi_obs, 3);
        do_write(1'b0, 1'b0, gi_obs, gd_obs);
        check_eq("wrap_then0", gi_obs, 0);

        // Full blocks grants.
        full = 1'b1;
        req  = 4'b0001;
        for (int c = 0; c < 20; c++) begin
            tick();
            check_eq("full_block", write_req, 0);
        end
        full = 1'b0;
        do_write(1'b0, 1'b0, gi_obs, gd_obs);
        check_eq("full_release", gi_obs, 0);

        // writeAck while idle is ignored.
        req       = '0;
        write_ack = 1'b1;
        tick();
        write_ack = 1'b0;
        check_eq("stray_ack_busy", busy, 0);
        check_eq("stray_ack_wreq", write_req, 0);
        tick();
        check_eq("stray_ack_ack", ack, 0);

        // req dropped during GRANT: write completes, ack still pulses.
        set_word(2, 16'hbeef);
        req = 4'b0100;
        do_write(1'b1, 1'b0, gi_obs, gd_obs);
        check_eq("drop_idx", gi_obs, 2);

        // Reset in the middle of a write.
        set_word(1, 16'h0bad);
        req = 4'b0010;
        tick();
        check_eq("mid_wreq", write_req, 1);
        check_eq("mid_grant", grant_idx, 1);
        tick();
        tick();
        rst = 1'b1;
        tick();
        check_eq("mid_rst_wreq", write_req, 0);
        check_eq("mid_rst_ack", ack, 0);
        check_eq("mid_rst_grant", grant_idx, 0);
        check_eq("mid_rst_busy", busy, 0);
        rst = 1'b0;
        ptr_model = 0;
        for (int i = 0; i < N; i++) wait_cnt[i] = 0;
        do_write(1'b0, 1'b0, gi_obs, gd_obs);
        check_eq("regrant_idx", gi_obs, 1);
        check_eq("regrant_data", gd_obs, 16'h0bad);

        // Randomized traffic.
        for (int t = 0; t < 60; t++) begin
            for (int i = 0; i < N; i++) begin
                if (!req[i] && $urandom_range(0, 2) == 0) begin
                    set_word(i, 16'($urandom));
                    req[i] = 1'b1;
                    wait_cnt[i] = 0;
                end
            end
            if (req == '0) begin
                int j;
                j = $urandom_range(0, N - 1);
                set_word(j, 16'($urandom));
                req[j] = 1'b1;
                wait_cnt[j] = 0;
            end
            if ($urandom_range(0, 4) == 0) begin
                full = 1'b1;
                for (int c = 0; c < 3; c++) begin
                    tick();
                    check_eq("rnd_full_block", write_req, 0);
                end
                full = 1'b0;
            end
            do_write(1'b0, 1'b0, gi_obs, gd_obs);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
